// File: rtl/serial_byte_packer_if.sv
// serial_byte_packer_if
//   Bundles the asynchronous serial input pins and the assembled-byte
//   outputs of serial_byte_packer.
//   master : the serial source / byte consumer (drives ser_*, reads results)
//   slave  : the packer itself (reads ser_*, drives results)
//   Signals:
//     ser_data, ser_strobe, ser_frame : async serial stream (data, bit strobe, frame gate)
//     byte_out[7:0]  : last completed byte
//     byte_valid     : one-cycle pulse, byte_out is new
//     frame_err      : one-cycle pulse, frame dropped with a partial byte
//     par_err        : one-cycle pulse, parity mismatch (parity build only)
//     bit_cnt[3:0]   : bits collected in the current byte
//     byte_cnt[7:0]  : completed-byte counter (wraps)
interface serial_byte_packer_if;
  logic       ser_data;
  logic       ser_strobe;
  logic       ser_frame;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       frame_err;
  logic       par_err;
  logic [3:0] bit_cnt;
  logic [7:0] byte_cnt;

  modport master (
    output ser_data, ser_strobe, ser_frame,
    input  byte_out, byte_valid, frame_err, par_err, bit_cnt, byte_cnt
  );

  modport slave (
    input  ser_data, ser_strobe, ser_frame,
    output byte_out, byte_valid, frame_err, par_err, bit_cnt, byte_cnt
  );
endinterface

// File: rtl/serial_byte_packer.sv
// serial_byte_packer
//   Synchronises a slow asynchronous serial stream (data + strobe + frame),
//   assembles the bits into bytes and presents each byte with a one-cycle
//   valid pulse for the downstream delay-line shift register.
//   Ports:
//     clk    : system clock, all flops on posedge
//     rst_n  : asynchronous active-low reset
//     bus    : serial_byte_packer_if.slave (serial inputs, byte/status outputs)
//   Parameters:
//     SYNC_STAGES : synchroniser depth, 2..4
//     MSB_FIRST   : 1 = first bit lands in byte_out[7], 0 = in byte_out[0]
//   Configuration macro:
//     SERIAL_BYTE_PACKER_PARITY_EN : 9-bit bytes with trailing even-parity bit;
//     when undefined, 8-bit bytes and par_err is tied low.
module serial_byte_packer #(
  parameter int SYNC_STAGES = 2,
  parameter int MSB_FIRST   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_byte_packer_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;

`ifdef SERIAL_BYTE_PACKER_PARITY_EN
  // Even parity over data plus parity bit: the XOR of all nine bits must be 0.
  function automatic logic even_parity_ok(input logic [7:0] data, input logic par);
    return ~((^data) ^ par);
  endfunction
`endif

  // {frame, strobe, data} travel together so they stay mutually aligned.
  logic [2:0] sync_r [SYNC_STAGES];
  logic       strb_q;
  logic       data_s;
  logic       strb_s;
  logic       frame_s;
  logic       strb_rise;
  logic [7:0] shifted_s;

  state_t     state_r,      state_nxt;
  logic [7:0] acc_r,        acc_nxt;
  logic [3:0] bit_cnt_r,    bit_cnt_nxt;
  logic [7:0] byte_cnt_r,   byte_cnt_nxt;
  logic [7:0] byte_out_r,   byte_out_nxt;
  logic       byte_valid_r, byte_valid_nxt;
  logic       frame_err_r,  frame_err_nxt;
`ifdef SERIAL_BYTE_PACKER_PARITY_EN
  logic       par_err_r,    par_err_nxt;
`endif

  assign data_s    = sync_r[SYNC_STAGES-1][0];
  assign strb_s    = sync_r[SYNC_STAGES-1][1];
  assign frame_s   = sync_r[SYNC_STAGES-1][2];
  assign strb_rise = strb_s & ~strb_q;
  assign shifted_s = (MSB_FIRST != 0) ? {acc_r[6:0], data_s} : {data_s, acc_r[7:1]};

  // Input synchroniser chain plus one extra strobe flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= 3'b000;
      end
      strb_q <= 1'b0;
    end else begin
      sync_r[0] <= {bus.ser_frame, bus.ser_strobe, bus.ser_data};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      strb_q <= strb_s;
    end
  end

  // State, accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      acc_r        <= 8'h00;
      bit_cnt_r    <= 4'd0;
      byte_cnt_r   <= 8'd0;
      byte_out_r   <= 8'h00;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
`ifdef SERIAL_BYTE_PACKER_PARITY_EN
      par_err_r    <= 1'b0;
`endif
    end else begin
      state_r      <= state_nxt;
      acc_r        <= acc_nxt;
      bit_cnt_r    <= bit_cnt_nxt;
      byte_cnt_r   <= byte_cnt_nxt;
      byte_out_r   <= byte_out_nxt;
      byte_valid_r <= byte_valid_nxt;
      frame_err_r  <= frame_err_nxt;
`ifdef SERIAL_BYTE_PACKER_PARITY_EN
      par_err_r    <= par_err_nxt;
`endif
    end
  end

  // Next-state and output decode; a falling frame always beats a strobe edge.
  always_comb begin
    state_nxt      = state_r;
    acc_nxt        = acc_r;
    bit_cnt_nxt    = bit_cnt_r;
    byte_cnt_nxt   = byte_cnt_r;
    byte_out_nxt   = byte_out_r;
    byte_valid_nxt = 1'b0;
    frame_err_nxt  = 1'b0;
`ifdef SERIAL_BYTE_PACKER_PARITY_EN
    par_err_nxt    = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        bit_cnt_nxt = 4'd0;
        acc_nxt     = 8'h00;
        if (frame_s) begin
          state_nxt = COLLECT;
        end else begin
          state_nxt = IDLE;
        end
      end
      COLLECT: begin
        if (!frame_s) begin
          state_nxt   = IDLE;
          bit_cnt_nxt = 4'd0;
          acc_nxt     = 8'h00;
          if (bit_cnt_r != 4'd0) begin
            frame_err_nxt = 1'b1;
          end else begin
            frame_err_nxt = 1'b0;
          end
        end else if (strb_rise) begin
`ifdef SERIAL_BYTE_PACKER_PARITY_EN
          // Ninth bit is parity only; it is checked, never shifted in.
          if (bit_cnt_r == 4'd8) begin
            bit_cnt_nxt = 4'd0;
            acc_nxt     = 8'h00;
            if (even_parity_ok(acc_r, data_s)) begin
              byte_out_nxt   = acc_r;
              byte_valid_nxt = 1'b1;
              byte_cnt_nxt   = byte_cnt_r + 8'd1;
            end else begin
              par_err_nxt = 1'b1;
            end
          end else begin
            acc_nxt     = shifted_s;
            bit_cnt_nxt = bit_cnt_r + 4'd1;
          end
`else
          if (bit_cnt_r == 4'd7) begin
            bit_cnt_nxt    = 4'd0;
            acc_nxt        = 8'h00;
            byte_out_nxt   = shifted_s;
            byte_valid_nxt = 1'b1;
            byte_cnt_nxt   = byte_cnt_r + 8'd1;
          end else begin
            acc_nxt     = shifted_s;
            bit_cnt_nxt = bit_cnt_r + 4'd1;
          end
`endif
        end else begin
          state_nxt = COLLECT;
        end
      end
      default: begin
        state_nxt   = IDLE;
        bit_cnt_nxt = 4'd0;
        acc_nxt     = 8'h00;
      end
    endcase
  end

  assign bus.byte_out   = byte_out_r;
  assign bus.byte_valid = byte_valid_r;
  assign bus.frame_err  = frame_err_r;
  assign bus.bit_cnt    = bit_cnt_r;
  assign bus.byte_cnt   = byte_cnt_r;
`ifdef SERIAL_BYTE_PACKER_PARITY_EN
  assign bus.par_err    = par_err_r;
`else
  assign bus.par_err    = 1'b0;
`endif

endmodule

// File: tb/tb_serial_byte_packer.sv
// tb_serial_byte_packer
//   Directed bench for serial_byte_packer. Two instances share one serial
//   stream: dut_a (MSB_FIRST=1) and dut_b (MSB_FIRST=0), both SYNC_STAGES=2.
//   Inputs change on the falling clock edge; outputs are sampled there too.
module tb_serial_byte_packer;

`ifdef SERIAL_BYTE_PACKER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ser_data = 1'b0;
  logic ser_strobe = 1'b0;
  logic ser_frame = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int lat_seen = 0;
  int vcnt_a = 0;
  int ferr_a = 0;
  int perr_a = 0;
  int v0, f0, p0;

  always #5 clk = ~clk;

  serial_byte_packer_if bus_a();
  serial_byte_packer_if bus_b();

  assign bus_a.ser_data   = ser_data;
  assign bus_a.ser_strobe = ser_strobe;
  assign bus_a.ser_frame  = ser_frame;
  assign bus_b.ser_data   = ser_data;
  assign bus_b.ser_strobe = ser_strobe;
  assign bus_b.ser_frame  = ser_frame;

  serial_byte_packer #(.SYNC_STAGES(2), .MSB_FIRST(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave)
  );
  serial_byte_packer #(.SYNC_STAGES(2), .MSB_FIRST(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave)
  );

  // Pulse monitor: counts high cycles of each single-cycle status output.
  always @(negedge clk) begin
    if (bus_a.byte_valid) vcnt_a <= vcnt_a + 1;
    if (bus_a.frame_err)  ferr_a <= ferr_a + 1;
    if (bus_a.par_err)    perr_a <= perr_a + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One strobe period of 8 clocks; records when byte_valid first appears.
  task automatic send_bit(input logic b);
    ser_data   = b;
    ser_strobe = 1'b1;
    lat_seen   = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (bus_a.byte_valid && lat_seen == 0) lat_seen = i;
    end
    ser_strobe = 1'b0;
    tick(4);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
`ifdef SERIAL_BYTE_PACKER_PARITY_EN
    send_bit(^v);
`endif
  endtask

  task automatic frame_on();
    ser_frame = 1'b1;
    tick(4);
  endtask

  task automatic frame_off();
    ser_frame = 1'b0;
    tick(4);
  endtask

  task automatic snap();
    tick(1);
    v0 = vcnt_a;
    f0 = ferr_a;
    p0 = perr_a;
  endtask

  initial begin
    // Reset state
    tick(3);
    check_val("rst_byte_out",   bus_a.byte_out,   8'h00);
    check_val("rst_byte_valid", bus_a.byte_valid, 1'b0);
    check_val("rst_frame_err",  bus_a.frame_err,  1'b0);
    check_val("rst_par_err",    bus_a.par_err,    1'b0);
    check_val("rst_bit_cnt",    bus_a.bit_cnt,    4'd0);
    check_val("rst_byte_cnt",   bus_a.byte_cnt,   8'd0);
    rst_n = 1'b1;
    tick(3);

    // Preload a byte so the mid-byte reset has something to clear
    frame_on();
    send_byte(8'h5A);
    check_val("pre_byte_out", bus_a.byte_out, 8'h5A);
    check_val("pre_byte_cnt", bus_a.byte_cnt, 8'd1);
    frame_off();

    // T1: reset after 5 bits
    frame_on();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    check_val("t1_bit_cnt5", bus_a.bit_cnt, 4'd5);
    rst_n = 1'b0;
    ser_frame = 1'b0;
    #1;
    check_val("t1_rst_byte_out", bus_a.byte_out, 8'h00);
    check_val("t1_rst_byte_cnt", bus_a.byte_cnt, 8'd0);
    check_val("t1_rst_bit_cnt",  bus_a.bit_cnt,  4'd0);
    check_val("t1_rst_valid",    bus_a.byte_valid, 1'b0);
    tick(3);
    rst_n = 1'b1;
    tick(3);
    snap();
    frame_on();
    send_byte(8'hA5);
    check_val("t1_latency",  lat_seen,       3);
    check_val("t1_byte_out", bus_a.byte_out, 8'hA5);
    check_val("t1_byte_cnt", bus_a.byte_cnt, 8'd1);
    check_val("t1_pulses",   vcnt_a - v0,    1);
    frame_off();

    // T2: back-to-back bytes in one frame
    snap();
    frame_on();
    send_byte(8'h3C);
    check_val("t2_first",  bus_a.byte_out, 8'h3C);
    send_byte(8'hC3);
    check_val("t2_second", bus_a.byte_out, 8'hC3);
    check_val("t2_byte_cnt", bus_a.byte_cnt, 8'd3);
    frame_off();
    check_val("t2_pulses",    vcnt_a - v0, 2);
    check_val("t2_no_ferr",   ferr_a - f0, 0);

    // T3: abort after 3 bits
    snap();
    frame_on();
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    check_val("t3_bit_cnt3", bus_a.bit_cnt, 4'd3);
    frame_off();
    check_val("t3_ferr",      ferr_a - f0,    1);
    check_val("t3_no_valid",  vcnt_a - v0,    0);
    check_val("t3_byte_out",  bus_a.byte_out, 8'hC3);
    check_val("t3_byte_cnt",  bus_a.byte_cnt, 8'd3);
    check_val("t3_bit_cnt0",  bus_a.bit_cnt,  4'd0);
    frame_on();
    send_byte(8'h81);
    check_val("t3_next_byte", bus_a.byte_out, 8'h81);
    check_val("t3_next_cnt",  bus_a.byte_cnt, 8'd4);
    frame_off();

    // T4: frame falls together with the final strobe edge
    snap();
    frame_on();
    for (int i = 0; i < NB - 1; i++) send_bit(1'b0);
    ser_data   = 1'b1;
    ser_frame  = 1'b0;
    ser_strobe = 1'b1;
    tick(4);
    ser_strobe = 1'b0;
    tick(4);
    check_val("t4_no_valid", vcnt_a - v0,    0);
    check_val("t4_ferr",     ferr_a - f0,    1);
    check_val("t4_byte_cnt", bus_a.byte_cnt, 8'd4);
    check_val("t4_byte_out", bus_a.byte_out, 8'h81);
    check_val("t4_bit_cnt",  bus_a.bit_cnt,  4'd0);

    // T5: bit order, then byte_cnt wrap
    frame_on();
    send_byte(8'h80);
    check_val("t5_msb_first", bus_a.byte_out, 8'h80);
    check_val("t5_lsb_first", bus_b.byte_out, 8'h01);
    check_val("t5_byte_cnt",  bus_a.byte_cnt, 8'd5);
    for (int i = 0; i < 250; i++) send_byte(8'(i));
    check_val("t5_cnt_255",   bus_a.byte_cnt, 8'd255);
    send_byte(8'h6E);
    check_val("t5_cnt_wrap",  bus_a.byte_cnt, 8'd0);
    check_val("t5_wrap_data", bus_a.byte_out, 8'h6E);
    frame_off();

`ifdef SERIAL_BYTE_PACKER_PARITY_EN
    // T6: parity good / bad
    snap();
    frame_on();
    for (int i = 7; i >= 0; i--) send_bit(i < 3 ? 1'b1 : 1'b0);
    send_bit(1'b1);
    check_val("t6_good_valid", vcnt_a - v0,    1);
    check_val("t6_good_data",  bus_a.byte_out, 8'h07);
    check_val("t6_good_cnt",   bus_a.byte_cnt, 8'd1);
    for (int i = 7; i >= 0; i--) send_bit(i < 3 ? 1'b1 : 1'b0);
    send_bit(1'b0);
    check_val("t6_bad_perr",   perr_a - p0,    1);
    check_val("t6_bad_novalid", vcnt_a - v0,   1);
    check_val("t6_bad_cnt",    bus_a.byte_cnt, 8'd1);
    check_val("t6_bad_bitcnt", bus_a.bit_cnt,  4'd0);
    frame_off();
`else
    check_val("par_err_tied", perr_a, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
